dmem_arbiter: RTL
=================

# dmem_arbiter

Shared-access controller for the CPU's 256 x 8 data RAM. Two requesters, port 0 for the core datapath and port 1 for the loader/debug side, compete for a single-port synchronous RAM through a req/gnt handshake. Arbitration is round-robin with optional locked bursts bounded by `MAX_BURST`. The block owns the RAM instance and returns read data one cycle after grant.

## Interface
- `ADDR_W`, 8, address width; RAM depth = 2^ADDR_W
- `DATA_W`, 8, data width
- `MAX_BURST`, 4, max consecutive locked grants to one port while the other port is waiting (>=1)

Ports, with x in {0,1}:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_x`  in  1  access request; hold with `we_x`/`addr_x`/`wdata_x` stable until `gnt_x`
- `lock_x`  in  1  keep ownership after this access (burst)
- `we_x`  in  1  1 = write, 0 = read
- `addr_x`  in  ADDR_W  RAM address
- `wdata_x`  in  DATA_W  write data
- `gnt_x`  out  1  combinational; access issues at the rising edge where `req_x & gnt_x`
- `rvalid_x`  out  1  one-cycle pulse, read data valid
- `rdata_x`  out  DATA_W  read data; holds until the next read completes on that port

## Operation
- Registered state:
  - `owner` ∈ {NONE, OWN0, OWN1}
  - `cnt`: burst count, saturating at MAX_BURST
  - `last`: port that last issued
- Per-cycle selection `sel`, at most one grant per cycle:
  - Case 1: `owner`=OWNk, `req_k`=1, `lock_k`=1, and (`cnt`<MAX_BURST or `req_other`=0). Select k.
  - Case 2: both requesting otherwise. Select `!last`.
  - Case 3: one requesting. Select it.
  - Case 4: none requesting. No grant.
- On an issue edge:
  - `last`<=sel.
  - If `lock_sel`: `owner`<=OWNsel. `cnt`<=1 if ownership is new, else min(`cnt`+1, MAX_BURST).
  - If not `lock_sel`: `owner`<=NONE, `cnt`<=0.
- Cycle with no issue: `owner`<=NONE, `cnt`<=0. An owner dropping `req` releases the lock.
- Forced hand-off: OWNk with `cnt`=MAX_BURST while the other port requests. The other port is granted, and the burst then restarts under the normal rules.
- Write: RAM updated at the issue edge; no `rvalid`.
- Read: RAM read at the issue edge. `rdata_sel`/`rvalid_sel` are set on the following edge.
- Read-after-write to the same address on the next cycle returns the new data.
- Addresses are used modulo 2^ADDR_W, no range check. Data is stored unmodified.

## Timing
- Grant latency: 0 cycles when uncontended (`gnt_x` in the same cycle as `req_x`).
- Contended, unlocked: strict alternation, one access per cycle, 100% RAM utilisation.
- Read latency: issue at edge N, `rvalid_x`=1 and `rdata_x` valid during cycle N+1 (after edge N+1).
- Back-to-back reads on one port give a continuous `rvalid`.
- Worst-case wait for a requesting port: MAX_BURST cycles.
- Reset values, applied immediately on `rst_n`=0 regardless of clock:
  - `owner`=NONE, `cnt`=0, `last`=1 (port 0 wins the first tie)
  - `rvalid_x`=0, `rdata_x`=0
  - `gnt_x` is low while `rst_n`=0
- Reset mid-read: a pending `rvalid` is discarded.
- RAM contents are not reset; they are zero-initialised in simulation.

## Structure
- Shared package `mincpu_pkg` holds:
  - `DATAMEM_ADDR_W`=8 and `DATAMEM_DATA_W`=8, matching the core's data RAM
  - `owner_t` enum {OWN_NONE, OWN0, OWN1}
- Sub-module `data_ram`: single-port, synchronous read/write, ADDR_W x DATA_W, no reset. The arbiter muxes the selected port onto it and steers the registered read data to the originating port via a registered `rd_port`/`rd_pend` pair.
- Arbiter FSM and counter stay in `dmem_arbiter`.

## Test plan
- Reset: hold `rst_n`=0 with random inputs. Required: `gnt_x`=0, `rvalid_x`=0, `rdata_x`=0x00. After release, first tie goes to port 0.
- Write/read: port 0 writes 0x5A to 0x10, then reads 0x10 next cycle. Required: `rvalid_0` one cycle later, `rdata_0`=0x5A, `rvalid_1` stays 0.
- Contention: both ports read every cycle, port 0 from 0x01 (holds 0x11), port 1 from 0x02 (holds 0x22), unlocked. Required: grants alternate 0,1,0,1. Each `rvalid_x` returns the correct byte.
- Burst bound, MAX_BURST=4: port 1 has a locked 6-write burst to 0x20..0x25 while port 0 requests continuously. Required grant order 1,1,1,1,0,1,1. Afterwards 0x20..0x25 read back the written values.
- Uncontended burst: port 0 makes 10 locked reads with `req_1`=0. Required: 10 consecutive `gnt_0`, `cnt` saturated at 4, no stall.
- Reset mid-read: port 1 read issued, then `rst_n`=0 before the next edge. Required: `rvalid_1` never asserts. After reset, `owner`=NONE and a new read completes normally.

Source files
------------

// File: rtl/mincpu_pkg.sv
// Shared definitions for the core's data-memory path: RAM geometry and
// the arbiter ownership encoding.
package mincpu_pkg;

  localparam int DATAMEM_ADDR_W = 8;
  localparam int DATAMEM_DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN0     = 2'd1,
    OWN1     = 2'd2
  } owner_t;

  function automatic owner_t owner_of(input logic port);
    return port ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous data RAM: write or registered read on enable, no reset.
module data_ram
  import mincpu_pkg::*;
#(
  parameter int ADDR_W = DATAMEM_ADDR_W,
  parameter int DATA_W = DATAMEM_DATA_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the data RAM, with locked bursts
// bounded by MAX_BURST while the other port waits.
module dmem_arbiter
  import mincpu_pkg::*;
#(
  parameter int ADDR_W    = DATAMEM_ADDR_W,
  parameter int DATA_W    = DATAMEM_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              lock_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic              gnt_0,
  output logic              rvalid_0,
  output logic [DATA_W-1:0] rdata_0,
  input  logic              req_1,
  input  logic              lock_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_1,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_1
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  owner_t            owner_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              last_reg;
  logic              rd_pend_reg;
  logic              rd_port_reg;

  logic              issue;
  logic              sel;
  logic              sel_lock;
  logic              sel_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [1:0]        gnt_vec;
  logic [1:0]        rvalid_vec;
  logic [DATA_W-1:0] rdata_arr [2];

  // A lock is honoured only until the burst count saturates with the other port waiting.
  always_comb begin
    issue = 1'b0;
    sel   = 1'b0;
    if (!rst_n) begin
      issue = 1'b0;
    end else if (owner_reg == OWN0 && req_0 && lock_0 && (cnt_reg < CNT_MAX || !req_1)) begin
      issue = 1'b1;
      sel   = 1'b0;
    end else if (owner_reg == OWN1 && req_1 && lock_1 && (cnt_reg < CNT_MAX || !req_0)) begin
      issue = 1'b1;
      sel   = 1'b1;
    end else if (req_0 && req_1) begin
      issue = 1'b1;
      sel   = !last_reg;
    end else if (req_0 || req_1) begin
      issue = 1'b1;
      sel   = req_1;
    end
  end

  assign sel_lock  = sel ? lock_1  : lock_0;
  assign sel_we    = sel ? we_1    : we_0;
  assign ram_addr  = sel ? addr_1  : addr_0;
  assign ram_wdata = sel ? wdata_1 : wdata_0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg   <= OWN_NONE;
      cnt_reg     <= '0;
      last_reg    <= 1'b1;
      rd_pend_reg <= 1'b0;
      rd_port_reg <= 1'b0;
    end else if (issue) begin
      last_reg    <= sel;
      rd_pend_reg <= !sel_we;
      rd_port_reg <= sel;
      if (sel_lock) begin
        owner_reg <= owner_of(sel);
        if (owner_reg != owner_of(sel)) cnt_reg <= CNT_W'(1);
        else if (cnt_reg < CNT_MAX)     cnt_reg <= cnt_reg + CNT_W'(1);
      end else begin
        owner_reg <= OWN_NONE;
        cnt_reg   <= '0;
      end
    end else begin
      owner_reg   <= OWN_NONE;
      cnt_reg     <= '0;
      rd_pend_reg <= 1'b0;
    end
  end

  data_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .en    (issue),
    .we    (sel_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Steer the RAM's registered read data back to whichever port issued it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic              rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;

    assign gnt_vec[gi] = issue && (sel == 1'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= rd_pend_reg && (rd_port_reg == 1'(gi));
        if (rd_pend_reg && (rd_port_reg == 1'(gi))) rdata_reg <= ram_rdata;
      end
    end

    assign rvalid_vec[gi] = rvalid_reg;
    assign rdata_arr[gi]  = rdata_reg;
  end

  assign gnt_0    = gnt_vec[0];
  assign gnt_1    = gnt_vec[1];
  assign rvalid_0 = rvalid_vec[0];
  assign rvalid_1 = rvalid_vec[1];
  assign rdata_0  = rdata_arr[0];
  assign rdata_1  = rdata_arr[1];

endmodule
